// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and default widths for the RAM arbiter slice.
//   DEF_ADRS_W / DEF_DIN_W / DEF_DOUT_W : default RAM address, store-data and read-word widths
//   owner_e  : which port owns the current RAM access cycle (NONE, A = fetch, B = load/store)
//   LAST_A / LAST_B : encoding of the round-robin "last granted" pointer
package ram_arb_pkg;

  localparam int DEF_ADRS_W = 8;
  localparam int DEF_DIN_W  = 8;
  localparam int DEF_DOUT_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way combinational picker for the RAM arbiter.
//   i_req[1:0] : requests, bit 0 = port A (fetch), bit 1 = port B (load/store)
//   i_last     : last granted port (LAST_A / LAST_B)
//   o_gnt[1:0] : one-hot grant, same bit order as i_req
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (B always wins
// a tie, i_last ignored); left undefined, ties go to the port that was not
// granted last (round-robin).
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  // Pick the single winner from the current requests
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
`ifdef RAM_ARB_FIXED_PRIO_EN
      2'b11:   o_gnt = 2'b10;
`else
      2'b11: begin
        if (i_last == LAST_B) begin
          o_gnt = 2'b01;
        end else begin
          o_gnt = 2'b10;
        end
      end
`endif
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported RAM between the instruction-fetch
// port (A, read-only) and the load/store port (B, read/write). One access is
// accepted per cycle; the grant edge is followed by one RAM access cycle and
// then a one-cycle done pulse carrying the read word.
//   i_clk, i_rst_n            : clock (rising edge), async active-low reset
//   i_a_req, i_a_adrs         : fetch request/address, held until o_a_gnt
//   o_a_gnt                   : combinational, request taken at this edge
//   o_a_rdata, o_a_done       : fetched word, valid while o_a_done pulses
//   i_b_req, i_b_rw, i_b_adrs, i_b_din : load/store request (rw 1 = write)
//   o_b_gnt, o_b_rdata, o_b_done       : as for port A (rdata only for reads)
//   o_ram_rw, o_ram_adrs, o_ram_din    : drive the RAM
//   i_ram_dout                : RAM combinational read data
// Build option: RAM_ARB_FIXED_PRIO_EN (see rr_arb2) gives B fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADRS_W = DEF_ADRS_W,
  parameter int DIN_W  = DEF_DIN_W,
  parameter int DOUT_W = DEF_DOUT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_req,
  input  logic [ADRS_W-1:0] i_a_adrs,
  output logic              o_a_gnt,
  output logic [DOUT_W-1:0] o_a_rdata,
  output logic              o_a_done,
  input  logic              i_b_req,
  input  logic              i_b_rw,
  input  logic [ADRS_W-1:0] i_b_adrs,
  input  logic [DIN_W-1:0]  i_b_din,
  output logic              o_b_gnt,
  output logic [DOUT_W-1:0] o_b_rdata,
  output logic              o_b_done,
  output logic              o_ram_rw,
  output logic [ADRS_W-1:0] o_ram_adrs,
  output logic [DIN_W-1:0]  o_ram_din,
  input  logic [DOUT_W-1:0] i_ram_dout
);

  logic [1:0]        w_req;
  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;

  owner_e            r_owner;
  logic              r_last;
  logic [ADRS_W-1:0] r_adrs_q;
  logic [DIN_W-1:0]  r_din_q;
  logic              r_rw_q;
  logic              r_a_done;
  logic              r_b_done;
  logic [DOUT_W-1:0] r_a_rdata;
  logic [DOUT_W-1:0] r_b_rdata;

  assign w_req = {i_b_req, i_a_req};

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Grants are held off while reset is asserted so nothing is accepted
  // at the edge that releases reset.
  assign w_gnt   = w_pick & {2{i_rst_n}};
  assign o_a_gnt = w_gnt[0];
  assign o_b_gnt = w_gnt[1];

  // Latch the winning request and record ownership / round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner  <= OWN_NONE;
      r_last   <= LAST_B;
      r_adrs_q <= {ADRS_W{1'b0}};
      r_din_q  <= {DIN_W{1'b0}};
      r_rw_q   <= 1'b0;
    end else begin
      case (w_gnt)
        2'b01: begin
          r_owner  <= OWN_A;
          r_last   <= LAST_A;
          r_adrs_q <= i_a_adrs;
          r_rw_q   <= 1'b0;
        end
        2'b10: begin
          r_owner  <= OWN_B;
          r_last   <= LAST_B;
          r_adrs_q <= i_b_adrs;
          r_din_q  <= i_b_din;
          r_rw_q   <= i_b_rw;
        end
        default: begin
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Close the access cycle: pulse done and capture read data for the owner
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_rdata <= {DOUT_W{1'b0}};
      r_b_rdata <= {DOUT_W{1'b0}};
    end else begin
      r_a_done <= (r_owner == OWN_A);
      r_b_done <= (r_owner == OWN_B);
      if (r_owner == OWN_A) begin
        r_a_rdata <= i_ram_dout;
      end
      // A store leaves the last load word visible.
      if ((r_owner == OWN_B) && !r_rw_q) begin
        r_b_rdata <= i_ram_dout;
      end
    end
  end

  // rw_q can stay set after a store, so the write strobe is qualified by
  // ownership; both terms are reset asynchronously, which kills an
  // in-flight write the moment reset asserts.
  assign o_ram_rw   = r_rw_q & (r_owner != OWN_NONE);
  assign o_ram_adrs = r_adrs_q;
  assign o_ram_din  = r_din_q;
  assign o_a_done   = r_a_done;
  assign o_b_done   = r_b_done;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rdata  = r_b_rdata;

endmodule
